lot_controller: RTL and testbench
=================================

LOT_CONTROLLER -- requirements
Module: lot_controller

Interface
REQ-001 The block SHALL have parameter CAPACITY, default 16, meaning the maximum number of cars in the lot (1..255).
REQ-002 The block SHALL have parameter GATE_TICKS, default 8, meaning the number of cycles a gate stays open without a passage (1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port ab_in, input, 2 bits: entry-lane sensor pair {a,b}.
REQ-006 The block SHALL have port ab_out, input, 2 bits: exit-lane sensor pair {a,b}.
REQ-007 The block SHALL have port req_in, input, 1 bit: entry ticket request, level.
REQ-008 The block SHALL have port req_out, input, 1 bit: exit ticket request, level.
REQ-009 The block SHALL have port gate_in, output, 1 bit: entry gate open command.
REQ-010 The block SHALL have port gate_out, output, 1 bit: exit gate open command.
REQ-011 The block SHALL have port count, output, 8 bits: current occupancy.
REQ-012 The block SHALL have port full, output, 1 bit: high when count == CAPACITY.
REQ-013 The block SHALL have port err, output, 1 bit: sticky flag, high after an over- or underflow attempt.

Function
REQ-014 Each lane detector SHALL track the sequence ab = 00, 01, 11, 10, 00 with states IDLE, A, AB, B.
- IDLE: 01 -> A; else stay.
- A: 11 -> AB; 00 -> IDLE; else stay.
- AB: 10 -> B; 01 -> A; else stay.
- B: 00 -> IDLE; 11 -> AB; 01 -> A; 10 stay.
REQ-015 Each lane detector SHALL assert a combinational pass pulse in exactly the cycle where state == B and ab == 00.
REQ-016 An entry pass SHALL increment count at the next edge; an exit pass SHALL decrement count at the next edge (latency 1 cycle).
REQ-017 Simultaneous entry and exit passes SHALL leave count unchanged and SHALL NOT set err.
REQ-018 An entry pass alone at count == CAPACITY SHALL leave count unchanged and set err.
REQ-019 An exit pass alone at count == 0 SHALL leave count unchanged and set err.
REQ-020 Each gate FSM SHALL have states CLOSED and OPEN, with an 8-bit down-timer.
REQ-021 gate_in and gate_out SHALL be registered and equal to (state == OPEN).
REQ-022 The entry gate SHALL go CLOSED -> OPEN when req_in is high and full is low, loading the timer with GATE_TICKS.
REQ-023 The exit gate SHALL go CLOSED -> OPEN when req_out is high and count != 0, loading the timer with GATE_TICKS.
REQ-024 In OPEN, the own lane's pass pulse SHALL close the gate at the next edge; otherwise the timer SHALL decrement each cycle.
REQ-025 In OPEN, the gate SHALL close at the edge where the timer equals 1.
REQ-026 A pass and a timer expiry in the same cycle SHALL close the gate, and the pass SHALL still be counted.
REQ-027 A request held high while OPEN SHALL NOT reload the timer.
REQ-028 A request still high after the gate closes SHALL reopen it one cycle later, if the open condition holds.
REQ-029 Passes SHALL be counted regardless of gate state (tailgating is still counted).
REQ-030 full SHALL be combinational from count.

Reset
REQ-031 On reset, the block SHALL set count = 0, full = 0, err = 0, gate_in = 0, gate_out = 0, both detectors to IDLE, both gates to CLOSED and both timers to 0.
REQ-032 Reset asserted mid-sequence or while a gate is open SHALL override all other events in that cycle.

Structure
REQ-033 Package lot_pkg SHALL hold the detector state encoding, the gate state encoding and the 2-bit sensor constants (00, 01, 11, 10).
REQ-034 The lane detector SHALL be a sub-module lane_detector, instantiated twice, with ports clk, reset, ab and pass.
REQ-035 The gate FSMs and the occupancy counter SHALL live in lot_controller.

Verification
REQ-036 Reset, req_in = 1 -> gate_in = 1 two cycles later; ab_in 00, 01, 11, 10, 00 -> count = 1 and gate_in = 0 one cycle after the final 00.
REQ-037 req_in pulsed with no passage, GATE_TICKS = 8 -> gate_in high for exactly 8 cycles, then low; count stays 0.
REQ-038 CAPACITY = 2, two entries -> full = 1; req_in = 1 -> gate_in stays 0; a third entry pass -> count = 2 and err = 1.
REQ-039 count = 1, entry and exit passes in the same cycle -> count = 1 and err = 0; an exit pass at count = 0 -> count = 0 and err = 1.
REQ-040 Aborted sequence ab_in 01, 11, 01, 00 -> no pass and count unchanged; reset asserted while the detector is in B with gate_out open -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/lot_pkg.sv
// Shared definitions for the parking lot controller.
//   - det_state_t  : lane detector states. Each state is encoded as the last
//                    sensor code accepted in the 00-01-11-10-00 ring.
//   - gate_state_t : gate FSM states.
//   - AB_*         : 2-bit sensor pair constants {a,b}.
package lot_pkg;

    typedef enum logic [1:0] {
        DET_IDLE = 2'b00,
        DET_A    = 2'b01,
        DET_AB   = 2'b11,
        DET_B    = 2'b10
    } det_state_t;

    typedef enum logic {
        GATE_CLOSED = 1'b0,
        GATE_OPEN   = 1'b1
    } gate_state_t;

    localparam logic [1:0] AB_NONE = 2'b00;
    localparam logic [1:0] AB_A    = 2'b01;
    localparam logic [1:0] AB_BOTH = 2'b11;
    localparam logic [1:0] AB_B    = 2'b10;

endpackage

// File: rtl/lane_detector.sv
// Lane passage detector.
// Follows the sensor sequence 00 -> 01 -> 11 -> 10 -> 00 made by a car
// crossing the sensor pair. Partial or backed-out sequences fall back
// without producing a pass.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   ab    : sensor pair {a,b}
//   pass  : combinational one-cycle pulse when a full passage completes
module lane_detector
    import lot_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ab,
    output logic       pass
);

    det_state_t state_reg, state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= DET_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pass       = 1'b0;
        case (state_reg)
            DET_IDLE: begin
                if (ab == AB_A) state_next = DET_A;
            end
            DET_A: begin
                if (ab == AB_BOTH)      state_next = DET_AB;
                else if (ab == AB_NONE) state_next = DET_IDLE;
            end
            DET_AB: begin
                if (ab == AB_B)      state_next = DET_B;
                else if (ab == AB_A) state_next = DET_A;
            end
            DET_B: begin
                if (ab == AB_NONE) begin
                    state_next = DET_IDLE;
                    pass       = 1'b1;
                end else if (ab == AB_BOTH) begin
                    state_next = DET_AB;
                end else if (ab == AB_A) begin
                    state_next = DET_A;
                end
            end
            default: state_next = DET_IDLE;
        endcase
    end

endmodule

// File: rtl/lot_controller.sv
// Parking lot controller: two lane detectors, two timed gates and an
// occupancy counter with sticky over/underflow error.
// Lane 0 is the entry lane, lane 1 the exit lane.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous, active-high
//   ab_in    : entry-lane sensor pair {a,b}
//   ab_out   : exit-lane sensor pair {a,b}
//   req_in   : entry ticket request (level)
//   req_out  : exit ticket request (level)
//   gate_in  : entry gate open command
//   gate_out : exit gate open command
//   count    : current occupancy
//   full     : count == CAPACITY
//   err      : sticky over/underflow attempt flag
module lot_controller
    import lot_pkg::*;
#(
    parameter int CAPACITY   = 16,
    parameter int GATE_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ab_in,
    input  logic [1:0] ab_out,
    input  logic       req_in,
    input  logic       req_out,
    output logic       gate_in,
    output logic       gate_out,
    output logic [7:0] count,
    output logic       full,
    output logic       err
);

    localparam logic [7:0] CAP_VAL   = 8'(CAPACITY);
    localparam logic [7:0] TICKS_VAL = 8'(GATE_TICKS);

    logic [7:0] count_reg, count_next;
    logic       err_reg, err_next;

    logic [1:0] ab_lane [2];
    logic [1:0] pass_lane;
    logic [1:0] req_lane;
    logic [1:0] can_open;
    logic [1:0] gate_open;

    assign ab_lane[0] = ab_in;
    assign ab_lane[1] = ab_out;
    assign req_lane   = {req_out, req_in};

    // Entry may open only while there is room; exit only while a car is inside.
    assign can_open   = {(count_reg != 8'd0), ~full};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            gate_state_t gate_state_reg, gate_state_next;
            logic [7:0]  timer_reg, timer_next;

            lane_detector u_det (
                .clk   (clk),
                .reset (reset),
                .ab    (ab_lane[gi]),
                .pass  (pass_lane[gi])
            );

            always_ff @(posedge clk) begin
                if (reset) begin
                    gate_state_reg <= GATE_CLOSED;
                    timer_reg      <= 8'd0;
                end else begin
                    gate_state_reg <= gate_state_next;
                    timer_reg      <= timer_next;
                end
            end

            // A held request never reloads an open gate; it only matters
            // once the gate is closed again.
            always_comb begin
                gate_state_next = gate_state_reg;
                timer_next      = timer_reg;
                case (gate_state_reg)
                    GATE_CLOSED: begin
                        if (req_lane[gi] && can_open[gi]) begin
                            gate_state_next = GATE_OPEN;
                            timer_next      = TICKS_VAL;
                        end
                    end
                    GATE_OPEN: begin
                        if (pass_lane[gi] || (timer_reg == 8'd1)) begin
                            gate_state_next = GATE_CLOSED;
                            timer_next      = 8'd0;
                        end else begin
                            timer_next = timer_reg - 8'd1;
                        end
                    end
                    default: begin
                        gate_state_next = GATE_CLOSED;
                        timer_next      = 8'd0;
                    end
                endcase
            end

            assign gate_open[gi] = (gate_state_reg == GATE_OPEN);
        end
    endgenerate

    // Passes are counted whatever the gate state; simultaneous entry and
    // exit cancel out without any boundary check.
    always_comb begin
        count_next = count_reg;
        err_next   = err_reg;
        case (pass_lane)
            2'b01: begin
                if (count_reg == CAP_VAL) err_next = 1'b1;
                else                      count_next = count_reg + 8'd1;
            end
            2'b10: begin
                if (count_reg == 8'd0) err_next = 1'b1;
                else                   count_next = count_reg - 8'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= 8'd0;
            err_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    assign count    = count_reg;
    assign full     = (count_reg == CAP_VAL);
    assign err      = err_reg;
    assign gate_in  = gate_open[0];
    assign gate_out = gate_open[1];

endmodule

// File: tb/tb_lot_controller.sv
module tb_lot_controller;

    localparam int CAP = 2;
    localparam int GT  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] ab_in = 2'b00;
    logic [1:0] ab_out = 2'b00;
    logic       req_in = 1'b0;
    logic       req_out = 1'b0;
    logic       gate_in, gate_out, full, err;
    logic [7:0] count;

    int checks = 0;
    int failures = 0;

    // Reference model: each lane remembers the last sensor code it accepted
    // along the crossing ring; a gate is an open flag plus cycles remaining.
    int         m_count;
    bit         m_err;
    bit         m_open [2];
    int         m_left [2];
    logic [1:0] m_last [2];

    lot_controller #(.CAPACITY(CAP), .GATE_TICKS(GT)) dut (
        .clk      (clk),
        .reset    (reset),
        .ab_in    (ab_in),
        .ab_out   (ab_out),
        .req_in   (req_in),
        .req_out  (req_out),
        .gate_in  (gate_in),
        .gate_out (gate_out),
        .count    (count),
        .full     (full),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] accept(input logic [1:0] last, input logic [1:0] ab);
        bit ok;
        case (last)
            2'b00:   ok = (ab == 2'b01);
            2'b01:   ok = (ab == 2'b11) || (ab == 2'b00);
            2'b11:   ok = (ab == 2'b10) || (ab == 2'b01);
            default: ok = (ab != 2'b10);
        endcase
        return ok ? ab : last;
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_err   = 1'b0;
        for (int l = 0; l < 2; l++) begin
            m_open[l] = 1'b0;
            m_left[l] = 0;
            m_last[l] = 2'b00;
        end
    endtask

    // Called just after a rising edge; inputs still hold their pre-edge values.
    task automatic model_update();
        bit         p [2];
        bit         req, cond, full_old, nz_old;
        logic [1:0] abv [2];
        abv[0] = ab_in;
        abv[1] = ab_out;
        for (int l = 0; l < 2; l++) p[l] = (m_last[l] == 2'b10) && (abv[l] == 2'b00);
        if (reset) begin
            model_reset();
        end else begin
            full_old = (m_count == CAP);
            nz_old   = (m_count != 0);
            for (int l = 0; l < 2; l++) begin
                req  = (l == 0) ? req_in : req_out;
                cond = (l == 0) ? !full_old : nz_old;
                if (!m_open[l]) begin
                    if (req && cond) begin
                        m_open[l] = 1'b1;
                        m_left[l] = GT;
                    end
                end else if (p[l] || m_left[l] == 1) begin
                    m_open[l] = 1'b0;
                end else begin
                    m_left[l]--;
                end
            end
            if (p[0] && !p[1]) begin
                if (m_count == CAP) m_err = 1'b1;
                else                m_count++;
            end else if (p[1] && !p[0]) begin
                if (m_count == 0) m_err = 1'b1;
                else              m_count--;
            end
            for (int l = 0; l < 2; l++) m_last[l] = accept(m_last[l], abv[l]);
        end
    endtask

    task automatic step(input logic [1:0] ai, input logic [1:0] ao,
                        input logic ri, input logic ro, input logic rst);
        @(negedge clk);
        ab_in   = ai;
        ab_out  = ao;
        req_in  = ri;
        req_out = ro;
        reset   = rst;
        @(posedge clk);
        model_update();
        #1;
        check("count", count, 8'(m_count));
        check("full", {7'd0, full}, {7'd0, (m_count == CAP)});
        check("err", {7'd0, err}, {7'd0, m_err});
        check("gate_in", {7'd0, gate_in}, {7'd0, m_open[0]});
        check("gate_out", {7'd0, gate_out}, {7'd0, m_open[1]});
    endtask

    task automatic pass_seq(input bit do_in, input bit do_out);
        logic [1:0] seq [4];
        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        for (int i = 0; i < 4; i++)
            step(do_in ? seq[i] : 2'b00, do_out ? seq[i] : 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [1:0] ring_next(input logic [1:0] v);
        case (v)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    initial begin
        int         hi;
        logic [1:0] di, dout;
        model_reset();

        // Reset and entry with gate.
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        check("reset_count", count, 8'd0);
        check("reset_gates", {6'd0, gate_in, gate_out}, 8'd0);
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        check("entry_gate_opened", {7'd0, gate_in}, 8'd1);
        pass_seq(1'b1, 1'b0);
        check("entry_count", count, 8'd1);
        check("entry_gate_closed", {7'd0, gate_in}, 8'd0);
        $display("txn entry_with_gate count=%0d", count);

        // Timeout without a passage.
        step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        hi = gate_in ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
            if (gate_in) hi++;
        end
        check("timeout_open_cycles", 8'(hi), 8'(GT));
        check("timeout_count", count, 8'd1);
        $display("txn gate_timeout open_cycles=%0d", hi);

        // Aborted sequence.
        step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        check("abort_count", count, 8'd1);
        $display("txn aborted_sequence count=%0d", count);

        // Fill to capacity, then overflow attempt.
        pass_seq(1'b1, 1'b0);
        check("full_flag", {7'd0, full}, 8'd1);
        for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        check("full_gate_shut", {7'd0, gate_in}, 8'd0);
        pass_seq(1'b1, 1'b0);
        check("overflow_count", count, 8'd2);
        check("overflow_err", {7'd0, err}, 8'd1);
        $display("txn overflow count=%0d err=%0d", count, err);

        // Simultaneous passes and underflow.
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        pass_seq(1'b1, 1'b0);
        pass_seq(1'b1, 1'b1);
        check("simul_count", count, 8'd1);
        check("simul_err", {7'd0, err}, 8'd0);
        pass_seq(1'b0, 1'b1);
        check("exit_count", count, 8'd0);
        pass_seq(1'b0, 1'b1);
        check("underflow_count", count, 8'd0);
        check("underflow_err", {7'd0, err}, 8'd1);
        $display("txn simultaneous_and_underflow count=%0d err=%0d", count, err);

        // Reset while exit detector sits in B with the exit gate open.
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        pass_seq(1'b1, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        check("exit_gate_opened", {7'd0, gate_out}, 8'd1);
        step(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        step(2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
        step(2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        check("midreset_outputs", {3'd0, gate_in, gate_out, full, err, 1'b0}, 8'd0);
        check("midreset_count", count, 8'd0);
        step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        check("post_reset_count", count, 8'd0);
        $display("txn reset_in_B count=%0d gate_out=%0d", count, gate_out);

        // Randomized traffic, mostly well-formed crossings with noise.
        di   = 2'b00;
        dout = 2'b00;
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < 100; i++) begin
                di   = ($urandom_range(3) != 0) ? ring_next(di)   : 2'($urandom);
                dout = ($urandom_range(3) != 0) ? ring_next(dout) : 2'($urandom);
                step(di, dout, ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                     ($urandom_range(299) == 0));
            end
            $display("txn random_batch %0d count=%0d err=%0d", b, count, err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
